// File: rtl/irrig_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irrig_pkg
//  Description : Shared types, display constants and the sensor-code decoder
//                for the multi-zone irrigation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package irrig_pkg;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    typedef struct packed {
        logic       legal;
        logic [3:0] level;
    } thermo_t;

    // Level is the popcount; a code is legal when it is all ones from bit 0
    // upward (code & (code+1) == 0), which also accepts the empty code.
    function automatic thermo_t thermo_level(input logic [8:0] code);
        thermo_t    res;
        logic [9:0] inc;
        res.level = 4'd0;
        for (int i = 0; i < 9; i++) begin
            res.level = res.level + {3'b000, code[i]};
        end
        inc       = {1'b0, code} + 10'd1;
        res.legal = ((inc[8:0] & code) == 9'd0);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irrig_zone_ctrl_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irrig_debounce
//  Description : Per-zone sensor debouncer. A raw vector is accepted once it
//                has been sampled identical on DEB_CYCLES consecutive edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module irrig_debounce #(
    parameter int NSENS      = 2,
    parameter int DEB_CYCLES = 3
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [NSENS-1:0] sens,
    output logic [NSENS-1:0] dvec,
    output logic             dvalid
);

    localparam int c_cnt_w = $clog2(DEB_CYCLES + 1);

    logic [NSENS-1:0]   r_last;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [NSENS-1:0]   r_dvec;
    logic               r_dvalid;

    // Run length of the current sample; a change restarts at one, and the
    // count saturates so a long-stable input keeps being re-accepted.
    always_comb begin
        w_cnt_nxt = c_cnt_w'(1);
        if (sens == r_last) begin
            if (r_cnt == c_cnt_w'(DEB_CYCLES)) begin
                w_cnt_nxt = r_cnt;
            end else begin
                w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
        end
    end

    // Track the last sample and publish it once the run is long enough.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= '0;
            r_cnt    <= '0;
            r_dvec   <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_last <= sens;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == c_cnt_w'(DEB_CYCLES)) begin
                r_dvec   <= sens;
                r_dvalid <= 1'b1;
            end
        end
    end

    assign dvec   = r_dvec;
    assign dvalid = r_dvalid;

endmodule
`default_nettype wire

// File: rtl/irrig_zone_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irrig_zone_ctrl
//  Description : Multi-zone irrigation controller. Debounces per-zone
//                thermometer level sensors, fills low zones one at a time
//                (round-robin), flags illegal codes / stuck fills and shows
//                the served zone on a seven-segment display.
//                Optional macro IRRIG_TIMEOUT_EN compiles in the fill timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module irrig_zone_ctrl
    import irrig_pkg::*;
#(
    parameter  int NZONES       = 2,
    parameter  int NSENS        = 2,
    parameter  int DEB_CYCLES   = 3,
    parameter  int LOW_TH       = 1,
    parameter  int FILL_TIMEOUT = 15,
    localparam int ZONE_W       = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic                    clk_2,
    input  logic                    rst_n,
    input  logic [NZONES*NSENS-1:0] sens,
    input  logic                    clr_fault,
    output logic [NZONES-1:0]       valve,
    output logic                    pump,
    output logic [NZONES-1:0]       fault,
    output logic [ZONE_W-1:0]       zone_idx,
    output logic [7:0]              seg
);

    localparam logic [NZONES-1:0] c_one    = NZONES'(1);
    localparam logic [ZONE_W-1:0] c_last   = ZONE_W'(NZONES - 1);
    localparam logic [3:0]        c_low_th = 4'(LOW_TH);
    localparam logic [3:0]        c_full   = 4'(NSENS);

    logic [NSENS-1:0]  w_dvec [NZONES];
    thermo_t           w_th   [NZONES];
    logic [NZONES-1:0] w_dvalid;
    logic [NZONES-1:0] w_illegal;
    logic [NZONES-1:0] w_eligible;

    state_t            r_state;
    logic [ZONE_W-1:0] r_ptr;
    logic [ZONE_W-1:0] r_active;
    logic [NZONES-1:0] r_valve;
    logic              r_pump;
    logic [NZONES-1:0] r_fault;
    logic [ZONE_W-1:0] r_zone_idx;
    logic [7:0]        r_seg;

    logic [ZONE_W-1:0] w_ptr_inc;
    logic [ZONE_W-1:0] w_act_inc;
    logic              w_full;
    logic              w_timeout;
    logic              w_fill_done;
    logic [NZONES-1:0] w_fault_set;
    logic [NZONES-1:0] w_fault_nxt;
    logic [ZONE_W-1:0] w_zone_nxt;
    logic [7:0]        w_seg_nxt;

    generate
        for (genvar z = 0; z < NZONES; z++) begin : g_zone
            irrig_debounce #(
                .NSENS      (NSENS),
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk_2  (clk_2),
                .rst_n  (rst_n),
                .sens   (sens[z*NSENS +: NSENS]),
                .dvec   (w_dvec[z]),
                .dvalid (w_dvalid[z])
            );
            assign w_th[z]       = thermo_level(9'(w_dvec[z]));
            assign w_illegal[z]  = w_dvalid[z] & ~w_th[z].legal;
            assign w_eligible[z] = w_dvalid[z] & ~r_fault[z] & (w_th[z].level < c_low_th);
        end
    endgenerate

    assign w_ptr_inc = (r_ptr    == c_last) ? '0 : r_ptr    + 1'b1;
    assign w_act_inc = (r_active == c_last) ? '0 : r_active + 1'b1;
    assign w_full    = (w_th[r_active].level == c_full);

`ifdef IRRIG_TIMEOUT_EN
    localparam int c_tw = (FILL_TIMEOUT > 0) ? $clog2(FILL_TIMEOUT + 1) : 1;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_inc;
    assign w_timer_inc = r_timer + 1'b1;
    // Fires on the FILL edge at which the timer would reach the limit.
    assign w_timeout   = (r_state == FILL) && !w_full && (w_timer_inc >= c_tw'(FILL_TIMEOUT));
`else
    // No fill timer in this build; FILL_TIMEOUT has no effect.
    assign w_timeout = (FILL_TIMEOUT < 0);
`endif

    // Leave FILL on full level or any fault on the active zone, including one
    // being raised this very edge, so the valve closes with the flag.
    assign w_fill_done = w_full | r_fault[r_active] | w_illegal[r_active] | w_timeout;

    assign w_fault_set = w_illegal | (w_timeout ? (c_one << r_active) : '0);
    assign w_fault_nxt = (clr_fault ? '0 : r_fault) | w_fault_set;

    // Sticky fault flags; a set overrides a simultaneous clear.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= '0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end

    // Scan / fill sequencer with registered valve and pump drives.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SCAN;
            r_ptr    <= '0;
            r_active <= '0;
            r_valve  <= '0;
            r_pump   <= 1'b0;
`ifdef IRRIG_TIMEOUT_EN
            r_timer  <= '0;
`endif
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_eligible[r_ptr]) begin
                        r_state  <= FILL;
                        r_active <= r_ptr;
                        r_valve  <= c_one << r_ptr;
                        r_pump   <= 1'b1;
`ifdef IRRIG_TIMEOUT_EN
                        r_timer  <= '0;
`endif
                    end else begin
                        r_ptr <= w_ptr_inc;
                    end
                end
                FILL: begin
                    if (w_fill_done) begin
                        r_state <= SCAN;
                        r_ptr   <= w_act_inc;
                        r_valve <= '0;
                        r_pump  <= 1'b0;
                    end else begin
`ifdef IRRIG_TIMEOUT_EN
                        r_timer <= w_timer_inc;
`endif
                    end
                end
                default: begin
                    r_state <= SCAN;
                    r_valve <= '0;
                    r_pump  <= 1'b0;
                end
            endcase
        end
    end

    // Zone shown after this edge mirrors the sequencer's next active/ptr.
    always_comb begin
        w_zone_nxt = r_ptr;
        if (r_state == FILL) begin
            w_zone_nxt = w_fill_done ? w_act_inc : r_active;
        end else if (!w_eligible[r_ptr]) begin
            w_zone_nxt = w_ptr_inc;
        end
    end

    // Pattern for the zone about to be displayed.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        if (w_fault_nxt[w_zone_nxt]) begin
            w_seg_nxt = SEG_F;
        end else if (w_dvalid[w_zone_nxt]) begin
            w_seg_nxt = SEG_DIGIT[w_th[w_zone_nxt].level];
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_zone_idx <= '0;
            r_seg      <= SEG_BLANK;
        end else begin
            r_zone_idx <= w_zone_nxt;
            r_seg      <= w_seg_nxt;
        end
    end

    assign valve    = r_valve;
    assign pump     = r_pump;
    assign fault    = r_fault;
    assign zone_idx = r_zone_idx;
    assign seg      = r_seg;

endmodule
`default_nettype wire
